// File: rtl/fir_tap_sequencer_if.sv
// Sample, coefficient and result handshake bundle for the FIR tap sequencer.
// Latency: none, this file only groups wires.
// Backpressure: in_ready/out_ready carry the flow control in each direction.
interface fir_tap_sequencer_if #(
    parameter int NUM_REGS   = 8,
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16
);
    localparam int AW = $clog2(NUM_REGS);

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  coef_we;
    logic [AW-1:0]         coef_addr;
    logic [COEF_WIDTH-1:0] coef_data;
    logic                  coef_err;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  busy;

    // Upstream/downstream side: drives samples, coefficients and result acceptance.
    modport master (
        output in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
        input  in_ready, coef_err, out_valid, out_data, busy
    );

    // Filter side.
    modport slave (
        input  in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
        output in_ready, coef_err, out_valid, out_data, busy
    );
endinterface

// File: rtl/fir_tap_sequencer.sv
// Time-multiplexed FIR: one shared signed MAC walks NUM_REGS taps over a circular sample buffer.
// Latency: sample accepted at edge N -> out_valid from cycle N+NUM_REGS+1; one sample per NUM_REGS+2 cycles.
// Backpressure: result held in OUTPUT until out_ready; in_ready only in IDLE. Macro FIR_SAT_EN saturates out_data.
module fir_tap_sequencer #(
    parameter int NUM_REGS   = 8,
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    fir_tap_sequencer_if.slave    bus
);
    localparam int PW        = $clog2(NUM_REGS);
    localparam int PROD_W    = DATA_WIDTH + COEF_WIDTH;
    localparam int ACC_WIDTH = DATA_WIDTH + COEF_WIDTH + $clog2(NUM_REGS);
    localparam logic [PW-1:0] LAST = PW'(NUM_REGS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_OUTPUT} state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic signed [DATA_WIDTH-1:0]  r_buf  [NUM_REGS];
    logic signed [COEF_WIDTH-1:0]  r_coef [NUM_REGS];
    logic signed [ACC_WIDTH-1:0]   r_acc;
    logic [PW-1:0]                 r_wr_ptr;
    logic [PW-1:0]                 r_rd_ptr;
    logic [PW-1:0]                 r_tap;
    logic [DATA_WIDTH-1:0]         r_out_data;
    logic                          r_out_valid;
    logic                          r_busy;
    logic                          r_coef_err;

    logic signed [PROD_W-1:0]      w_prod;
    logic signed [ACC_WIDTH-1:0]   w_acc_nxt;
    logic [DATA_WIDTH-1:0]         w_result;
    logic                          w_last;
    logic                          w_accept;

    assign w_accept  = (r_state == S_IDLE) && bus.in_valid;
    assign w_last    = (r_tap == LAST);
    assign w_prod    = r_buf[r_rd_ptr] * r_coef[r_tap];
    // Guard bits above the product mean this sum can never overflow.
    assign w_acc_nxt = r_acc + {{(ACC_WIDTH-PROD_W){w_prod[PROD_W-1]}}, w_prod};

`ifdef FIR_SAT_EN
    logic signed [ACC_WIDTH-1:0]   w_acc_sh;
    logic                          w_ovf;
    assign w_acc_sh = w_acc_nxt >>> (COEF_WIDTH-1);
    // Bits above the output sign must all match it, otherwise the value is out of range.
    assign w_ovf    = !(&w_acc_sh[ACC_WIDTH-1:DATA_WIDTH-1]) && (|w_acc_sh[ACC_WIDTH-1:DATA_WIDTH-1]);
    assign w_result = !w_ovf ? w_acc_sh[DATA_WIDTH-1:0] :
                      (w_acc_sh[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                             : {1'b0, {(DATA_WIDTH-1){1'b1}}});
`else
    // Plain truncating wrap of the Q-aligned accumulator.
    assign w_result = w_acc_nxt[COEF_WIDTH-1 +: DATA_WIDTH];
`endif

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.busy      = r_busy;
    assign bus.coef_err  = r_coef_err;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state decode: accept -> walk every tap -> hold result until taken.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (bus.in_valid)  w_state_nxt = S_ACCUM;
            S_ACCUM:  if (w_last)        w_state_nxt = S_OUTPUT;
            S_OUTPUT: if (bus.out_ready) w_state_nxt = S_IDLE;
            default:                     w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: sample capture, MAC sequencing, coefficient bank and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_buf[i]  <= '0;
                r_coef[i] <= '0;
            end
            r_acc       <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_tap       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_coef_err  <= 1'b0;
        end else begin
            r_coef_err <= 1'b0;
            // Bank only changes while no computation is reading it.
            if (bus.coef_we) begin
                if (r_state == S_IDLE) r_coef[bus.coef_addr] <= bus.coef_data;
                else                   r_coef_err <= 1'b1;
            end
            if (w_accept) begin
                r_buf[r_wr_ptr] <= bus.in_data;
                r_rd_ptr        <= r_wr_ptr;
                r_wr_ptr        <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
                r_tap           <= '0;
                r_acc           <= '0;
                r_busy          <= 1'b1;
            end
            if (r_state == S_ACCUM) begin
                r_acc    <= w_acc_nxt;
                r_tap    <= r_tap + 1'b1;
                r_rd_ptr <= (r_rd_ptr == '0) ? LAST : r_rd_ptr - 1'b1;
                if (w_last) begin
                    r_out_data  <= w_result;
                    r_out_valid <= 1'b1;
                end
            end
            if (r_state == S_OUTPUT && bus.out_ready) begin
                r_out_valid <= 1'b0;
                r_busy      <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer with NUM_REGS=4, DATA_WIDTH=16, COEF_WIDTH=16.
// Latency: checks out_valid timing relative to each accepted sample.
// Backpressure: holds out_ready low to check output hold and in_ready blocking.
module tb_fir_tap_sequencer;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fir_tap_sequencer_if #(.NUM_REGS(N), .DATA_WIDTH(16), .COEF_WIDTH(16)) bus ();

    fir_tap_sequencer #(.NUM_REGS(N), .DATA_WIDTH(16), .COEF_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] smp;
        logic [15:0] exp;
    } vec_t;

    int total = 0;
    int bad   = 0;
    logic [15:0] sb[$];
    logic signed [15:0] hist[$];
    logic signed [15:0] m_coef[N];
    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_y();
        longint acc = 0;
        longint sh;
        logic [15:0] r;
        for (int k = 0; k < N; k++)
            if (k < hist.size()) acc += longint'(m_coef[k]) * longint'(hist[k]);
        sh = acc >>> 15;
`ifdef FIR_SAT_EN
        if (sh > 32767)       r = 16'h7FFF;
        else if (sh < -32768) r = 16'h8000;
        else                  r = sh[15:0];
`else
        r = sh[15:0];
`endif
        return r;
    endfunction

    task automatic model_clear();
        hist.delete();
        sb.delete();
        for (int k = 0; k < N; k++) m_coef[k] = '0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        model_clear();
    endtask

    task automatic wr_coef(input int a, input logic [15:0] d);
        @(negedge clk);
        bus.coef_we = 1'b1; bus.coef_addr = a[1:0]; bus.coef_data = d;
        @(posedge clk); #1;
        bus.coef_we = 1'b0;
        m_coef[a] = d;
    endtask

    // Drive one sample; optionally push the model's or a given expectation.
    task automatic do_accept(input logic [15:0] d, input bit use_exp, input logic [15:0] exp, input bit push);
        int n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = d;
        while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
        if (!bus.in_ready) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        hist.push_front(d);
        if (hist.size() > N) void'(hist.pop_back());
        if (push) sb.push_back(use_exp ? exp : model_y());
    endtask

    task automatic wait_result(input string name, input bit chk_lat);
        int cnt = 0;
        logic [15:0] e;
        do begin @(negedge clk); cnt++; end while (!bus.out_valid && cnt < 50);
        if (!bus.out_valid) begin
            chk({name, "_timeout"}, 0, 1);
        end else begin
            if (chk_lat) chk({name, "_lat"}, cnt, 5);
            e = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
            chk(name, bus.out_data, e);
            @(posedge clk); #1;
        end
    endtask

    task automatic xfer(input string name, input logic [15:0] d, input bit use_exp, input logic [15:0] exp);
        do_accept(d, use_exp, exp, 1'b1);
        wait_result(name, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] held;
        int n;
        vecs[0] = '{16'h4000, 16'h2000};
        vecs[1] = '{16'h0000, 16'h1000};
        vecs[2] = '{16'h0000, 16'h0800};
        vecs[3] = '{16'h0000, 16'h0400};
        vecs[4] = '{16'h0000, 16'h0000};
`ifdef FIR_SAT_EN
        vecs[5] = '{16'h7FFF, 16'h7FFE};
        vecs[6] = '{16'h7FFF, 16'h7FFF};
        vecs[7] = '{16'h7FFF, 16'h7FFF};
        vecs[8] = '{16'h7FFF, 16'h7FFF};
`else
        vecs[5] = '{16'h7FFF, 16'h7FFE};
        vecs[6] = '{16'h7FFF, 16'hFFFC};
        vecs[7] = '{16'h7FFF, 16'h7FFA};
        vecs[8] = '{16'h7FFF, 16'hFFF8};
`endif
        bus.in_valid = 1'b0; bus.in_data = '0; bus.coef_we = 1'b0;
        bus.coef_addr = '0; bus.coef_data = '0; bus.out_ready = 1'b1;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;

        // Reset state.
        chk("rst_in_ready",  bus.in_ready,  1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data",  bus.out_data,  0);
        chk("rst_busy",      bus.busy,      0);
        chk("rst_coef_err",  bus.coef_err,  0);

        // Impulse response from the table.
        wr_coef(0, 16'h4000); wr_coef(1, 16'h2000); wr_coef(2, 16'h1000); wr_coef(3, 16'h0800);
        for (int i = 0; i < 5; i++) xfer($sformatf("impulse%0d", i), vecs[i].smp, 1'b1, vecs[i].exp);

        // Full-scale accumulation: saturated or wrapped depending on build.
        for (int k = 0; k < N; k++) wr_coef(k, 16'h7FFF);
        for (int i = 5; i < 9; i++) xfer($sformatf("sat%0d", i - 5), vecs[i].smp, 1'b1, vecs[i].exp);

        // Backpressure: result must hold while out_ready is low.
        bus.out_ready = 1'b0;
        do_accept(16'h0100, 1'b0, 16'h0, 1'b1);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.out_valid && n < 50);
        held = bus.out_data;
        chk("bp_data", held, (sb.size() > 0) ? sb.pop_front() : 16'hxxxx);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("bp_valid%0d", i), bus.out_valid, 1);
            chk($sformatf("bp_hold%0d", i),  bus.out_data,  held);
            chk($sformatf("bp_inrdy%0d", i), bus.in_ready,  0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_inrdy", bus.in_ready, 1);
        chk("bp_release_valid", bus.out_valid, 0);

        // Coefficient write while busy is dropped.
        do_accept(16'h2000, 1'b0, 16'h0, 1'b1);
        @(negedge clk);
        bus.coef_we = 1'b1; bus.coef_addr = 2'd1; bus.coef_data = 16'h1234;
        @(posedge clk); #1;
        bus.coef_we = 1'b0;
        @(negedge clk);
        chk("busy_err_pulse", bus.coef_err, 1);
        chk("busy_flag", bus.busy, 1);
        @(negedge clk);
        chk("busy_err_clear", bus.coef_err, 0);
        wait_result("busy_res0", 1'b0);
        xfer("busy_res1", 16'hC000, 1'b0, 16'h0);

        // Pointer wrap over nine samples.
        do_reset();
        for (int k = 0; k < N; k++) wr_coef(k, 16'h7FFF);
        for (int i = 1; i <= 9; i++) xfer($sformatf("wrap%0d", i), 16'(i * 1000), 1'b0, 16'h0);

        // Reset in the middle of an accumulation.
        do_accept(16'h1234, 1'b0, 16'h0, 1'b0);
        @(negedge clk); @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        model_clear();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rstmid_valid%0d", i), bus.out_valid, 0);
            @(negedge clk);
        end
        chk("rstmid_inrdy", bus.in_ready, 1);
        wr_coef(0, 16'h4000); wr_coef(1, 16'h2000);
        xfer("fresh0", 16'h4000, 1'b1, 16'h2000);
        xfer("fresh1", 16'h0000, 1'b1, 16'h1000);
        xfer("fresh2", 16'h0000, 1'b1, 16'h0000);
        xfer("fresh3", 16'h0000, 1'b1, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fir_tap_sequencer.md
# fir_tap_sequencer

Time-multiplexed FIR controller for the accelerator. It accepts input samples over a valid/ready handshake and stores them in a circular sample buffer of NUM_REGS entries. It sequences one signed multiply-accumulate per tap per cycle over that buffer and a programmable coefficient bank, then presents the filtered result over a valid/ready output handshake. It replaces the free-running delay line where one shared multiplier must serve all taps.

## Interface
- NUM_REGS, 8: number of taps and sample-buffer depth; must be at least 2.
- DATA_WIDTH, 16: signed sample width and output width, Q1.(DATA_WIDTH-1).
- COEF_WIDTH, 16: signed coefficient width, Q1.(COEF_WIDTH-1).
- ACC_WIDTH (localparam): DATA_WIDTH+COEF_WIDTH+$clog2(NUM_REGS).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample; reset value 1.
- in_data  in  DATA_WIDTH  signed input sample.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  $clog2(NUM_REGS)  tap index k.
- coef_data  in  COEF_WIDTH  signed coefficient value.
- coef_err  out  1  one-cycle pulse when a coefficient write is dropped; reset value 0.
- out_valid  out  1  result valid; reset value 0.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DATA_WIDTH  filtered sample; reset value 0.
- busy  out  1  high in ACCUM and OUTPUT; reset value 0.

## Operation
- Reset clears to 0: the sample buffer, the coefficient bank, the accumulator, wr_ptr, rd_ptr, tap and out_data. The state is set to IDLE.
- Result definition: y[n] = sum over k=0..NUM_REGS-1 of coef[k]*x[n-k]. x[n-k] is the sample accepted k accepts earlier; samples never written read as 0.
- FSM states: IDLE, ACCUM, OUTPUT.
- IDLE:
  - in_ready=1.
  - On in_valid: write in_data to buf[wr_ptr], set rd_ptr=wr_ptr, increment wr_ptr (wrapping NUM_REGS-1 to 0), clear tap and acc, and go to ACCUM.
- ACCUM:
  - Each cycle: acc += sext(buf[rd_ptr]*coef[tap]), tap++, rd_ptr-- (wrapping 0 to NUM_REGS-1).
  - After the tap=NUM_REGS-1 cycle, go to OUTPUT with out_data loaded from the final acc.
- OUTPUT:
  - out_valid=1, with out_data held stable.
  - On out_ready: out_valid drops next cycle and the FSM goes to IDLE.
- Arithmetic:
  - Products are full 2's-complement DATA_WIDTH+COEF_WIDTH bits, sign-extended into ACC_WIDTH. Guard bits make accumulator overflow impossible.
  - The output is taken from acc >>> (COEF_WIDTH-1); see Configuration.
- Coefficient writes:
  - Accepted only in IDLE.
  - A coef_we in ACCUM or OUTPUT is dropped, the bank is unchanged, and coef_err pulses for 1 cycle.
- Simultaneous events in IDLE: coef_we together with a sample accept is legal. The write lands at that edge and the new coefficient is used by the same computation.
- Reset mid-operation: an ACCUM or OUTPUT is abandoned, no out_valid is produced, and all state returns to reset values.

## Timing
- A sample accepted at edge N gives out_valid high from cycle N+NUM_REGS+1.
- Throughput: at most one sample per NUM_REGS+2 cycles when out_ready is held high.
- in_ready is combinational from state only (IDLE). It never depends on in_valid.
- out_valid, out_data and busy are registered.
- Backpressure: with out_ready low, out_valid and out_data hold indefinitely and in_ready stays 0.

## Configuration
- Macro: FIR_SAT_EN.
- Defined: out_data is the shifted accumulator saturated to the signed DATA_WIDTH range, i.e. clamped to 0x7FFF or 0x8000 for DATA_WIDTH=16.
- Undefined: out_data = acc[COEF_WIDTH-1 +: DATA_WIDTH]. This is a truncating wrap with no saturation logic.

## Test plan
All scenarios use NUM_REGS=4, DATA_WIDTH=16, COEF_WIDTH=16.
- Impulse: coefs {0x4000,0x2000,0x1000,0x0800}; accept 0x4000, then zeros. Required outputs: 0x2000, 0x1000, 0x0800, 0x0400, then 0x0000, with out_valid exactly 5 cycles after each accept.
- Saturation: all coefs 0x7FFF; four samples of 0x7FFF. The 4th output must be 0x7FFF with FIR_SAT_EN defined and 0xFFF8 without it.
- Backpressure: hold out_ready=0 for 10 cycles in OUTPUT. out_valid must stay 1, out_data must stay stable, and in_ready must stay 0. After out_ready=1, in_ready=1 on the next cycle.
- Busy write: coef_we to addr 1 with 0x1234 during ACCUM. Required: coef_err pulses for 1 cycle and the next result is computed with the old coef[1].
- Wrap-around: feed 9 samples 1..9 with coefs all 0x7FFF. Each result must equal the sum of the last 4 inputs times 0x7FFF, shifted as specified, across pointer wrap.
- Reset mid-ACCUM: assert rst at tap 2. out_valid must stay 0, and a following impulse must give the fresh impulse response (all history cleared, coefs 0 until reloaded).
